// File: rtl/shift_reg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl_if
// Brief    : Control/data bundle for the shift register with auto-shift.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_reg_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [CNT_W-1:0] n_shift;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output en, clr, mode, d, sin, start, n_shift,
    input  q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  en, clr, mode, d, sin, start, n_shift,
    output q, sout_l, sout_r, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl
// Brief    : WIDTH-bit shift/load register with manual modes and an
//            auto-shift controller (load, shift right N times, pulse done).
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  wire             clk,
  input  wire             rst_n,
  shift_reg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_MODE_HOLD  = 2'b00;
  localparam logic [1:0] c_MODE_LEFT  = 2'b01;
  localparam logic [1:0] c_MODE_RIGHT = 2'b10;
  localparam logic [1:0] c_MODE_LOAD  = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // busy/done are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.clr) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q <= bus.d;
            if (bus.n_shift != '0) begin
              r_cnt   <= bus.n_shift;
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            case (bus.mode)
              c_MODE_HOLD:  r_q <= r_q;
              c_MODE_LEFT:  r_q <= {r_q[WIDTH-2:0], bus.sin};
              c_MODE_RIGHT: r_q <= {bus.sin, r_q[WIDTH-1:1]};
              c_MODE_LOAD:  r_q <= bus.d;
              default:      r_q <= r_q;
            endcase
          end
        end
        S_SHIFT: begin
          r_q   <= {bus.sin, r_q[WIDTH-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q      = r_q;
  assign bus.sout_l = r_q[WIDTH-1];
  assign bus.sout_r = r_q[0];
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_ctrl
// Brief    : Scoreboard bench for shift_reg_ctrl: directed scenarios plus
//            randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  shift_reg_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: register value, shifts still owed, pending done pulse.
  logic [7:0] m_q;
  int         m_rem;
  bit         m_done;

  function automatic void model_reset();
    m_q    = 8'h00;
    m_rem  = 0;
    m_done = 1'b0;
  endfunction

  function automatic void model_step(bit en, bit clr, logic [1:0] mode,
                                     logic [7:0] d, bit sin, bit start, int n);
    if (clr) begin
      model_reset();
    end else if (!en) begin
      // frozen
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_q   = (m_q >> 1) | (8'(sin) << 7);
      m_rem = m_rem - 1;
      if (m_rem == 0) m_done = 1'b1;
    end else if (start) begin
      m_q = d;
      if (n > 0) m_rem = n;
      else       m_done = 1'b1;
    end else begin
      case (mode)
        2'b01:   m_q = (m_q << 1) | 8'(sin);
        2'b10:   m_q = (m_q >> 1) | (8'(sin) << 7);
        2'b11:   m_q = d;
        default: m_q = m_q;
      endcase
    end
  endfunction

  // Drive one clock worth of inputs and queue what the DUT must show after it.
  task automatic cycle(bit en, bit clr, logic [1:0] mode, logic [7:0] d,
                       bit sin, bit start, int n);
    exp_t e;
    @(negedge clk);
    bus.en      = en;
    bus.clr     = clr;
    bus.mode    = mode;
    bus.d       = d;
    bus.sin     = sin;
    bus.start   = start;
    bus.n_shift = CNT_W'(n);
    model_step(en, clr, mode, d, sin, start, n);
    e.q    = m_q;
    e.busy = (m_rem > 0);
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic compare(string name, logic [7:0] q, logic busy, logic done,
                         logic [7:0] eq, logic ebusy, logic edone);
    checks++;
    if (q !== eq || busy !== ebusy || done !== edone ||
        bus.sout_l !== eq[7] || bus.sout_r !== eq[0]) begin
      errors++;
      $display("FAIL %s: got q=%h busy=%b done=%b sl=%b sr=%b, expected q=%h busy=%b done=%b",
               name, q, busy, done, bus.sout_l, bus.sout_r, eq, ebusy, edone);
    end
  endtask

  // Directed check against a fixed value, taken just after the coming edge.
  task automatic check_now(string name, logic [7:0] eq, logic ebusy, logic edone);
    @(posedge clk);
    #2;
    compare(name, bus.q, bus.busy, bus.done, eq, ebusy, edone);
  endtask

  // Monitor: every cycle the DUT presents a new output, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare("scoreboard", bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  end

  initial begin
    logic [7:0] steps [4];
    rst_n = 1'b0;
    bus.en = 1'b1; bus.clr = 1'b0; bus.mode = 2'b00; bus.d = '0;
    bus.sin = 1'b0; bus.start = 1'b0; bus.n_shift = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare("reset_state", bus.q, bus.busy, bus.done, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Manual modes
    cycle(1, 0, 2'b11, 8'hA5, 0, 0, 0); check_now("load_A5", 8'hA5, 0, 0);
    cycle(1, 0, 2'b01, 8'h00, 1, 0, 0); check_now("shl_sin1", 8'h4B, 0, 0);
    cycle(1, 0, 2'b10, 8'h00, 0, 0, 0); check_now("shr_sin0", 8'h25, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 2'b00, 8'h00, 1, 0, 0); check_now("hold", 8'h25, 0, 0);
    end

    // Auto-shift N=4
    steps[0] = 8'h78; steps[1] = 8'h3C; steps[2] = 8'h1E; steps[3] = 8'h0F;
    cycle(1, 0, 2'b01, 8'hF0, 0, 1, 4); check_now("auto_load", 8'hF0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("auto_shift", steps[i], 1, 0);
    end
    cycle(1, 0, 2'b00, 8'h00, 0, 1, 3); check_now("auto_done", 8'h0F, 0, 1);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("auto_idle", 8'h0F, 0, 0);

    // Zero count
    cycle(1, 0, 2'b00, 8'h3C, 0, 1, 0); check_now("zero_done", 8'h3C, 0, 1);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("zero_idle", 8'h3C, 0, 0);

    // Enable stall after the 2nd shift
    cycle(1, 0, 2'b00, 8'hF0, 0, 1, 4); check_now("stall_load", 8'hF0, 1, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("stall_s1", 8'h78, 1, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("stall_s2", 8'h3C, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 2'b11, 8'hFF, 1, 1, 1); check_now("stall_frozen", 8'h3C, 1, 0);
    end
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("stall_s3", 8'h1E, 1, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("stall_done", 8'h0F, 0, 1);
    cycle(0, 0, 2'b00, 8'h00, 0, 0, 0); check_now("done_frozen", 8'h0F, 0, 1);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("stall_idle", 8'h0F, 0, 0);

    // Clear beats en=0, start and load
    cycle(1, 0, 2'b00, 8'hF0, 0, 1, 4); check_now("clr_load", 8'hF0, 1, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("clr_s1", 8'h78, 1, 0);
    cycle(0, 1, 2'b11, 8'hFF, 1, 1, 4); check_now("clr_apply", 8'h00, 0, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("clr_idle", 8'h00, 0, 0);

    // Asynchronous reset mid-operation
    cycle(1, 0, 2'b00, 8'hFF, 0, 1, 5); check_now("rst_load", 8'hFF, 1, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("rst_s1", 8'h7F, 1, 0);
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0); check_now("rst_s2", 8'h3F, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("async_reset", bus.q, bus.busy, bus.done, 8'h00, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 2'b00, 8'h00, 1, 0, 0); check_now("post_reset_idle", 8'h00, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
            2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
